mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 26, byte-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, read-beat width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, max consecutive demand grants while prefetch waits.
REQ-004 SHALL have port clk, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports d_arvalid in 1, d_arready out 1, d_araddr in ADDR_WIDTH, d_arlen in 4: demand (d_cache refill) read request.
REQ-007 SHALL have ports p_arvalid in 1, p_arready out 1, p_araddr in ADDR_WIDTH, p_arlen in 4: prefetch read request.
REQ-008 SHALL have ports m_arvalid out 1, m_arready in 1, m_araddr out ADDR_WIDTH, m_arlen out 4, m_arid out 4: shared memory read-address channel.
REQ-009 SHALL have ports m_rvalid in 1, m_rdata in DATA_WIDTH, m_rready out 1: shared memory read-data channel.
REQ-010 SHALL have ports d_rvalid out 1, d_rdata out DATA_WIDTH, p_rvalid out 1, p_rdata out DATA_WIDTH: routed read data.
REQ-011 SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, ADDR, DATA; exactly one burst outstanding.
REQ-013 IDLE: if any arvalid, SHALL grant, latch winner's addr/len/owner, go to ADDR next cycle; else stay.
REQ-014 Arbitration: demand wins by default; prefetch wins when both valid and starve_cnt == STARVE_LIMIT.
REQ-015 starve_cnt: +1 on demand grant with p_arvalid high (saturating at STARVE_LIMIT); cleared on prefetch grant or when p_arvalid low at grant.
REQ-016 ADDR: m_arvalid=1, m_araddr/m_arlen from latch, m_arid=1 demand / 2 prefetch; hold stable until m_arready.
REQ-017 Owner's arready SHALL pulse exactly the cycle m_arvalid&&m_arready; other requester's arready stays 0; then go to DATA.
REQ-018 Requesters hold arvalid/addr/len until own arready; arbiter does not re-sample during ADDR/DATA.
REQ-019 DATA: beat counter counts m_rvalid beats; m_rdata/m_rvalid routed combinationally (zero latency) to owner only.
REQ-020 Burst ends on beat number m_arlen (arlen 0 treated as 1 beat); SHALL return to IDLE the next cycle; new grant earliest cycle after that.
REQ-021 m_rready SHALL be 1 in all states; m_rvalid outside DATA SHALL be dropped (no d_/p_rvalid).
REQ-022 Non-owner rvalid SHALL be 0 at all times; rdata outputs may carry m_rdata but only qualified by rvalid.
REQ-023 Request arriving in ADDR/DATA SHALL wait; no request lost or duplicated.
REQ-024 m_arready asserted outside ADDR SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force state IDLE, starve_cnt 0, beat counter 0, latches 0.
REQ-026 During reset: m_arvalid, d_arready, p_arready, d_rvalid, p_rvalid, busy = 0; m_araddr, m_arlen, m_arid = 0; m_rready = 1.
REQ-027 Reset mid-burst SHALL abandon the burst; residual memory beats after release dropped per REQ-021.

Verification
REQ-028 Single demand: d_araddr=0x100, d_arlen=4, m_arready=1 -> m_arvalid cycle 2 with m_arid=1, d_arready 1 pulse; 4 beats 0xA0..0xA3 on d_rdata; busy low after 4th beat +1.
REQ-029 Simultaneous d/p valid, starve_cnt 0 -> demand granted first; prefetch granted on next IDLE, m_arid=2, beats only on p_rvalid.
REQ-030 Starvation: p_arvalid held, 4 back-to-back demands -> 5th grant goes to prefetch although d_arvalid high.
REQ-031 Backpressure: m_arready low 3 cycles in ADDR -> m_araddr/m_arid stable, arready not pulsed until m_arready.
REQ-032 Stray beat in IDLE and rst_n low in DATA after 2 of 4 beats -> no rvalid, state IDLE, all outputs per REQ-026.
REQ-033 arlen=0 -> single beat completes burst, return to IDLE.

Source files
------------

// File: rtl/mem_read_arbiter_if.sv
// Bundled request, memory and routed-data signals of the two-requester read arbiter.
// master is the arbiter side (it masters the shared memory channel); slave is everything around it.
interface mem_read_arbiter_if #(
    parameter int ADDR_WIDTH = 26,
    parameter int DATA_WIDTH = 32
);
    logic                  d_arvalid;
    logic                  d_arready;
    logic [ADDR_WIDTH-1:0] d_araddr;
    logic [3:0]            d_arlen;

    logic                  p_arvalid;
    logic                  p_arready;
    logic [ADDR_WIDTH-1:0] p_araddr;
    logic [3:0]            p_arlen;

    logic                  m_arvalid;
    logic                  m_arready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [3:0]            m_arlen;
    logic [3:0]            m_arid;

    logic                  m_rvalid;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_rready;

    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  p_rvalid;
    logic [DATA_WIDTH-1:0] p_rdata;

    modport master (
        input  d_arvalid, d_araddr, d_arlen,
        output d_arready,
        input  p_arvalid, p_araddr, p_arlen,
        output p_arready,
        output m_arvalid, m_araddr, m_arlen, m_arid,
        input  m_arready,
        input  m_rvalid, m_rdata,
        output m_rready,
        output d_rvalid, d_rdata, p_rvalid, p_rdata
    );

    modport slave (
        output d_arvalid, d_araddr, d_arlen,
        input  d_arready,
        output p_arvalid, p_araddr, p_arlen,
        input  p_arready,
        input  m_arvalid, m_araddr, m_arlen, m_arid,
        output m_arready,
        output m_rvalid, m_rdata,
        input  m_rready,
        input  d_rvalid, d_rdata, p_rvalid, p_rdata
    );
endinterface

// File: rtl/mem_read_arbiter.sv
// Arbitrates demand and prefetch read bursts onto one memory read channel, one burst in flight,
// with a starvation guard so prefetch gets through after STARVE_LIMIT consecutive demand wins.
module mem_read_arbiter #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_read_arbiter_if.master bus,
    output logic               busy
);
    // state | meaning
    // IDLE  | no burst; grant the winning requester when any arvalid is seen
    // ADDR  | presenting the latched request on m_ar*, waiting for m_arready
    // DATA  | routing m_rvalid beats to the owner until the last beat
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam int            SW         = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            len_q;
    logic [3:0]            arid_q;
    logic                  arvalid_q;
    logic [SW-1:0]         starve_cnt;
    logic [3:0]            beat_cnt;

    logic                  pick_p;
    logic                  handshake;
    logic                  owner_p;
    logic                  in_data;
    logic [3:0]            eff_len;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] rdata;

    assign pick_p    = bus.p_arvalid && (!bus.d_arvalid || starve_cnt == STARVE_MAX);
    assign owner_p   = arid_q[1];
    // arvalid_q is only ever set in ADDR, so m_arready elsewhere has no effect
    assign handshake = arvalid_q && bus.m_arready;
    assign in_data   = (state == DATA);
    assign eff_len   = (len_q == 4'd0) ? 4'd1 : len_q;
    assign last_beat = (beat_cnt == eff_len - 4'd1);
    assign rdata     = bus.m_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            arid_q     <= '0;
            arvalid_q  <= 1'b0;
            starve_cnt <= '0;
            beat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.d_arvalid || bus.p_arvalid) begin
                        addr_q    <= pick_p ? bus.p_araddr : bus.d_araddr;
                        len_q     <= pick_p ? bus.p_arlen  : bus.d_arlen;
                        arid_q    <= pick_p ? 4'd2 : 4'd1;
                        arvalid_q <= 1'b1;
                        beat_cnt  <= '0;
                        state     <= ADDR;
                        if (pick_p || !bus.p_arvalid)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                ADDR: begin
                    if (bus.m_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.m_rvalid) begin
                        if (last_beat) begin
                            beat_cnt <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_arvalid = arvalid_q;
    assign bus.m_araddr  = addr_q;
    assign bus.m_arlen   = len_q;
    assign bus.m_arid    = arid_q;
    assign bus.m_rready  = 1'b1;

    assign bus.d_arready = handshake && !owner_p;
    assign bus.p_arready = handshake &&  owner_p;

    // read data is routed with zero latency; only the qualifying rvalid is owner-specific
    assign bus.d_rvalid  = in_data && bus.m_rvalid && !owner_p;
    assign bus.p_rvalid  = in_data && bus.m_rvalid &&  owner_p;
    assign bus.d_rdata   = rdata;
    assign bus.p_rdata   = rdata;

    assign busy = (state != IDLE);
endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter: directed vector table, hand sequences for
// starvation/backpressure/reset, then random traffic against a transaction-level model.
module tb_mem_read_arbiter;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int LIM = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    mem_read_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_read_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int dv, pv, dlen, plen, ardy, rv, rd;
        int e_arv, e_id, e_len, e_dar, e_par, e_drv, e_prv, e_busy;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [3:0]    len;
    } req_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.d_arvalid = 1'b0; bus.d_araddr = '0; bus.d_arlen = '0;
        bus.p_arvalid = 1'b0; bus.p_araddr = '0; bus.p_arlen = '0;
        bus.m_arready = 1'b0; bus.m_rvalid = 1'b0; bus.m_rdata = '0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".m_arvalid"}, bus.m_arvalid, 0);
        chk({tag, ".d_arready"}, bus.d_arready, 0);
        chk({tag, ".p_arready"}, bus.p_arready, 0);
        chk({tag, ".d_rvalid"},  bus.d_rvalid,  0);
        chk({tag, ".p_rvalid"},  bus.p_rvalid,  0);
        chk({tag, ".busy"},      busy,          0);
        chk({tag, ".m_araddr"},  bus.m_araddr,  0);
        chk({tag, ".m_arlen"},   bus.m_arlen,   0);
        chk({tag, ".m_arid"},    bus.m_arid,    0);
        chk({tag, ".m_rready"},  bus.m_rready,  1);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 30 && busy; c++) tick();
        chk({tag, ".idle_timeout"}, busy, 0);
    endtask

    // single demand, stray beats, demand-over-prefetch tie, arlen=0, prefetch burst with backpressure
    task automatic run_table();
        vec_t tbl[16];
        //         dv pv dl pl ar rv rd      arv id ln dar par drv prv busy
        tbl[0]  = '{1, 0, 4, 0, 1, 1, 'hEE,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 4, 0, 1, 0, 'h00,  1, 1, 4, 1, 0, 0, 0, 1};
        tbl[2]  = '{0, 0, 0, 0, 1, 1, 'hA0,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[3]  = '{0, 0, 0, 0, 0, 1, 'hA1,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 'h00,  0, 0, 0, 0, 0, 0, 0, 1};
        tbl[5]  = '{0, 0, 0, 0, 0, 1, 'hA2,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[6]  = '{0, 0, 0, 0, 0, 1, 'hA3,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[7]  = '{1, 1, 0, 2, 0, 1, 'h55,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{1, 1, 0, 2, 1, 0, 'h00,  1, 1, 0, 1, 0, 0, 0, 1};
        tbl[9]  = '{0, 1, 0, 2, 0, 1, 'hB0,  0, 0, 0, 0, 0, 1, 0, 1};
        tbl[10] = '{0, 1, 0, 2, 0, 0, 'h00,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[11] = '{0, 1, 0, 2, 0, 0, 'h00,  1, 2, 2, 0, 0, 0, 0, 1};
        tbl[12] = '{0, 1, 0, 2, 1, 0, 'h00,  1, 2, 2, 0, 1, 0, 0, 1};
        tbl[13] = '{0, 0, 0, 0, 0, 1, 'hC0,  0, 0, 0, 0, 0, 0, 1, 1};
        tbl[14] = '{0, 0, 0, 0, 0, 1, 'hC1,  0, 0, 0, 0, 0, 0, 1, 1};
        tbl[15] = '{0, 0, 0, 0, 0, 1, 'hDD,  0, 0, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 16; i++) begin
            tick();
            bus.d_arvalid = 1'(tbl[i].dv);  bus.d_araddr = AW'('h100); bus.d_arlen = 4'(tbl[i].dlen);
            bus.p_arvalid = 1'(tbl[i].pv);  bus.p_araddr = AW'('h200); bus.p_arlen = 4'(tbl[i].plen);
            bus.m_arready = 1'(tbl[i].ardy); bus.m_rvalid = 1'(tbl[i].rv); bus.m_rdata = DW'(tbl[i].rd);
            settle();
            chk($sformatf("tbl[%0d].m_arvalid", i), bus.m_arvalid, 64'(tbl[i].e_arv));
            if (tbl[i].e_arv != 0) begin
                chk($sformatf("tbl[%0d].m_arid", i),   bus.m_arid,   64'(tbl[i].e_id));
                chk($sformatf("tbl[%0d].m_arlen", i),  bus.m_arlen,  64'(tbl[i].e_len));
                chk($sformatf("tbl[%0d].m_araddr", i), bus.m_araddr, (tbl[i].e_id == 2) ? 64'h200 : 64'h100);
            end
            chk($sformatf("tbl[%0d].d_arready", i), bus.d_arready, 64'(tbl[i].e_dar));
            chk($sformatf("tbl[%0d].p_arready", i), bus.p_arready, 64'(tbl[i].e_par));
            chk($sformatf("tbl[%0d].d_rvalid", i),  bus.d_rvalid,  64'(tbl[i].e_drv));
            chk($sformatf("tbl[%0d].p_rvalid", i),  bus.p_rvalid,  64'(tbl[i].e_prv));
            chk($sformatf("tbl[%0d].busy", i),      busy,          64'(tbl[i].e_busy));
            if (tbl[i].e_drv != 0) chk($sformatf("tbl[%0d].d_rdata", i), bus.d_rdata, 64'(tbl[i].rd));
            if (tbl[i].e_prv != 0) chk($sformatf("tbl[%0d].p_rdata", i), bus.p_rdata, 64'(tbl[i].rd));
        end
        tick();
        idle_inputs();
    endtask

    // prefetch held while demand keeps requesting: four demand grants, then prefetch
    task automatic run_starve();
        int ids[5];
        int n = 0;
        tick();
        bus.d_arvalid = 1'b1; bus.d_araddr = AW'('h40); bus.d_arlen = 4'd0;
        bus.p_arvalid = 1'b1; bus.p_araddr = AW'('h80); bus.p_arlen = 4'd0;
        bus.m_arready = 1'b1; bus.m_rvalid = 1'b1;     bus.m_rdata = DW'('h77);
        for (int c = 0; c < 60 && n < 5; c++) begin
            tick();
            settle();
            if (bus.m_arvalid && bus.m_arready) begin
                ids[n] = int'(bus.m_arid);
                n++;
            end
        end
        bus.d_arvalid = 1'b0;
        bus.p_arvalid = 1'b0;
        chk("starve.grant_count", 64'(n), 5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("starve.grant[%0d].arid", i), 64'(ids[i]), (i == 4) ? 64'd2 : 64'd1);
        wait_idle("starve");
        idle_inputs();
    endtask

    // m_arready held low for three ADDR cycles
    task automatic run_backpressure();
        tick();
        bus.d_arvalid = 1'b1; bus.d_araddr = AW'('h3C0); bus.d_arlen = 4'd2;
        settle();
        chk("bp.grant_cycle.busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            settle();
            chk($sformatf("bp.wait%0d.m_arvalid", c), bus.m_arvalid, 1);
            chk($sformatf("bp.wait%0d.m_araddr", c),  bus.m_araddr,  'h3C0);
            chk($sformatf("bp.wait%0d.m_arid", c),    bus.m_arid,    1);
            chk($sformatf("bp.wait%0d.d_arready", c), bus.d_arready, 0);
        end
        tick();
        bus.m_arready = 1'b1;
        settle();
        chk("bp.accept.d_arready", bus.d_arready, 1);
        chk("bp.accept.m_araddr",  bus.m_araddr,  'h3C0);
        tick();
        bus.d_arvalid = 1'b0; bus.m_arready = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = DW'('h5A);
        settle();
        chk("bp.beat0.d_rvalid", bus.d_rvalid, 1);
        chk("bp.beat0.d_rdata",  bus.d_rdata,  'h5A);
        tick();
        bus.m_rdata = DW'('h5B);
        settle();
        chk("bp.beat1.d_rvalid", bus.d_rvalid, 1);
        tick();
        bus.m_rvalid = 1'b0;
        settle();
        chk("bp.done.busy", busy, 0);
        idle_inputs();
    endtask

    // reset after two of four beats, then residual beats and a stray m_arready
    task automatic run_reset_mid();
        tick();
        bus.d_arvalid = 1'b1; bus.d_araddr = AW'('h500); bus.d_arlen = 4'd4; bus.m_arready = 1'b1;
        settle();
        tick();
        settle();
        chk("rmid.accept.d_arready", bus.d_arready, 1);
        tick();
        bus.d_arvalid = 1'b0; bus.m_rvalid = 1'b1; bus.m_rdata = DW'(1);
        settle();
        chk("rmid.beat0.d_rvalid", bus.d_rvalid, 1);
        tick();
        bus.m_rdata = DW'(2);
        settle();
        chk("rmid.beat1.d_rvalid", bus.d_rvalid, 1);
        rst_n = 1'b0;
        settle();
        check_reset("rmid.in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            settle();
            chk($sformatf("rmid.residual%0d.d_rvalid", c),  bus.d_rvalid,  0);
            chk($sformatf("rmid.residual%0d.busy", c),      busy,          0);
            chk($sformatf("rmid.residual%0d.d_arready", c), bus.d_arready, 0);
        end
        idle_inputs();
    endtask

    // random requesters and memory against a burst-level model of the arbitration rules
    task automatic run_random();
        req_t dq[$];
        req_t pq[$];
        req_t cur;
        bit   d_on = 0, p_on = 0;
        bit   act = 0, adone = 0, own_p = 0, pick_p;
        bit   exp_arv, hs, beat;
        int   left = 0, starve = 0, done_cycles = 0;
        for (int i = 0; i < 25; i++) dq.push_back('{AW'($urandom), 4'($urandom_range(0, 5))});
        for (int i = 0; i < 15; i++) pq.push_back('{AW'($urandom), 4'($urandom_range(0, 5))});
        for (int c = 0; c < 4000; c++) begin
            if (dq.size() == 0 && pq.size() == 0 && !act) break;
            done_cycles++;
            tick();
            if (!d_on && dq.size() > 0 && $urandom_range(0, 3) != 0) d_on = 1;
            if (!p_on && pq.size() > 0 && $urandom_range(0, 2) != 0) p_on = 1;
            bus.d_arvalid = d_on;
            bus.d_araddr  = d_on ? dq[0].addr : AW'($urandom);
            bus.d_arlen   = d_on ? dq[0].len  : 4'($urandom);
            bus.p_arvalid = p_on;
            bus.p_araddr  = p_on ? pq[0].addr : AW'($urandom);
            bus.p_arlen   = p_on ? pq[0].len  : 4'($urandom);
            bus.m_arready = ($urandom_range(0, 2) != 0);
            bus.m_rvalid  = 1'($urandom_range(0, 1));
            bus.m_rdata   = DW'($urandom);
            settle();

            exp_arv = act && !adone;
            hs      = exp_arv && bus.m_arready;
            beat    = act && adone && bus.m_rvalid;
            chk("rnd.m_arvalid", bus.m_arvalid, 64'(exp_arv));
            chk("rnd.busy",      busy,          64'(act));
            if (exp_arv) begin
                chk("rnd.m_araddr", bus.m_araddr, cur.addr);
                chk("rnd.m_arlen",  bus.m_arlen,  cur.len);
                chk("rnd.m_arid",   bus.m_arid,   own_p ? 64'd2 : 64'd1);
            end
            chk("rnd.d_arready", bus.d_arready, 64'(hs && !own_p));
            chk("rnd.p_arready", bus.p_arready, 64'(hs &&  own_p));
            chk("rnd.d_rvalid",  bus.d_rvalid,  64'(beat && !own_p));
            chk("rnd.p_rvalid",  bus.p_rvalid,  64'(beat &&  own_p));
            if (beat) chk("rnd.rdata", own_p ? bus.p_rdata : bus.d_rdata, bus.m_rdata);

            if (!act) begin
                if (d_on || p_on) begin
                    pick_p = p_on && (!d_on || starve == LIM);
                    cur    = pick_p ? pq[0] : dq[0];
                    own_p  = pick_p;
                    if (pick_p || !p_on) starve = 0;
                    else if (starve < LIM) starve = starve + 1;
                    left  = (cur.len == 0) ? 1 : int'(cur.len);
                    act   = 1;
                    adone = 0;
                end
            end else if (!adone) begin
                if (hs) begin
                    adone = 1;
                    if (own_p) begin void'(pq.pop_front()); p_on = 0; end
                    else       begin void'(dq.pop_front()); d_on = 0; end
                end
            end else if (bus.m_rvalid) begin
                left--;
                if (left == 0) act = 0;
            end
        end
        chk("rnd.drained", 64'(dq.size() + pq.size() + int'(act)), 0);
        chk("rnd.ran", 64'(done_cycles > 40), 1);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        bus.m_rvalid  = 1'b1;
        bus.m_arready = 1'b1;
        bus.d_arvalid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        run_table();
        run_starve();
        run_backpressure();
        run_reset_mid();
        run_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
